// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: loadable synchronous program memory feeding one
// instruction per clock to the cpu, with stall, halt sentinel and end-of-memory stop.
module instruction_fetch_unit #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned MEMORY_DEPTH  = 256,
  parameter logic [15:0] HALT_WORD     = 16'hFFFF,
  parameter logic [15:0] NOP_WORD      = 16'h9000
) (
  input  logic                     clock_in,
  input  logic                     power_on_reset_signal,
  input  logic                     load_enable,
  input  logic [ADDRESS_WIDTH-1:0] load_address,
  input  logic [15:0]              load_data,
  input  logic                     start,
  input  logic                     stall,
  output logic [15:0]              current_instruction,
  output logic                     instruction_valid,
  output logic [ADDRESS_WIDTH-1:0] program_counter,
  output logic                     busy,
  output logic                     halted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_HALTED
  } state_t;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(MEMORY_DEPTH - 1);

  state_t                     state;
  logic [15:0]                mem [MEMORY_DEPTH];
  logic [15:0]                fetch_word;
  logic [ADDRESS_WIDTH-1:0]   fetch_addr;
  logic                       end_pending;
  logic                       load_ok;
  logic                       advance;
  logic                       rd_en;
  logic [ADDRESS_WIDTH-1:0]   rd_addr;

  // Memory write/read qualifiers; the next word is only read when the current one is consumed.
  always_comb begin
    load_ok = load_enable && ((state == S_IDLE) || (state == S_HALTED)) &&
              (32'(load_address) < MEMORY_DEPTH);
    advance = (state == S_RUN) && !stall;
    rd_en   = (state == S_PRIME) ||
              (advance && !end_pending && (fetch_word != HALT_WORD) && (fetch_addr != LAST_ADDR));
    rd_addr = (state == S_PRIME) ? '0 : fetch_addr + ADDRESS_WIDTH'(1);
  end

  // Program memory: not cleared by reset, 1-cycle synchronous read.
  always_ff @(posedge clock_in) begin
    if (load_ok)
      mem[load_address] <= load_data;
    if (rd_en)
      fetch_word <= mem[rd_addr];
  end

  // Sequencer with registered outputs.
  always_ff @(posedge clock_in) begin
    if (power_on_reset_signal) begin
      state               <= S_IDLE;
      program_counter     <= '0;
      current_instruction <= NOP_WORD;
      instruction_valid   <= 1'b0;
      busy                <= 1'b0;
      halted              <= 1'b0;
      fetch_addr          <= '0;
      end_pending         <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALTED: begin
          if (start) begin
            state               <= S_PRIME;
            program_counter     <= '0;
            current_instruction <= NOP_WORD;
            instruction_valid   <= 1'b0;
            busy                <= 1'b1;
            halted              <= 1'b0;
            end_pending         <= 1'b0;
          end
        end
        S_PRIME: begin
          fetch_addr <= '0;
          state      <= S_RUN;
        end
        S_RUN: begin
          if (advance) begin
            if (end_pending || (fetch_word == HALT_WORD)) begin
              // End of memory keeps the last issued PC; a sentinel reports its own address.
              if (!end_pending)
                program_counter <= fetch_addr;
              state               <= S_HALTED;
              current_instruction <= NOP_WORD;
              instruction_valid   <= 1'b0;
              busy                <= 1'b0;
              halted              <= 1'b1;
            end else begin
              current_instruction <= fetch_word;
              instruction_valid   <= 1'b1;
              program_counter     <= fetch_addr;
              if (fetch_addr == LAST_ADDR)
                end_pending <= 1'b1;
              else
                fetch_addr <= fetch_addr + ADDRESS_WIDTH'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: vector table for the basic and stall
// sequences, hand-written sequences for fill, reset, load gating and sentinel cases.
module tb_instruction_fetch_unit;

  logic        clock_in = 1'b0;
  logic        power_on_reset_signal;
  logic        load_enable;
  logic [7:0]  load_address;
  logic [15:0] load_data;
  logic        start;
  logic        stall;
  logic [15:0] current_instruction;
  logic        instruction_valid;
  logic [7:0]  program_counter;
  logic        busy;
  logic        halted;

  int tests_run = 0;
  int tests_failed = 0;

  instruction_fetch_unit dut (
    .clock_in              (clock_in),
    .power_on_reset_signal (power_on_reset_signal),
    .load_enable           (load_enable),
    .load_address          (load_address),
    .load_data             (load_data),
    .start                 (start),
    .stall                 (stall),
    .current_instruction   (current_instruction),
    .instruction_valid     (instruction_valid),
    .program_counter       (program_counter),
    .busy                  (busy),
    .halted                (halted)
  );

  always #5 clock_in = ~clock_in;

  typedef struct {
    logic        rst;
    logic        start;
    logic        stall;
    logic [15:0] exp_instr;
    logic        exp_valid;
    logic [7:0]  exp_pc;
    logic        exp_busy;
    logic        exp_halted;
  } vec_t;

  vec_t vecs[$];

  task automatic idle_inputs();
    power_on_reset_signal = 1'b0;
    load_enable  = 1'b0;
    load_address = 8'd0;
    load_data    = 16'd0;
    start        = 1'b0;
    stall        = 1'b0;
  endtask

  // One clock edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] instr, input logic valid,
                       input logic [7:0] pc, input logic bsy, input logic hlt);
    tests_run++;
    if ({current_instruction, instruction_valid, program_counter, busy, halted} !==
        {instr, valid, pc, bsy, hlt}) begin
      tests_failed++;
      $display("FAIL %s: got instr=%h valid=%b pc=%0d busy=%b halted=%b, want instr=%h valid=%b pc=%0d busy=%b halted=%b",
               name, current_instruction, instruction_valid, program_counter, busy, halted,
               instr, valid, pc, bsy, hlt);
    end
  endtask

  task automatic load_word(input logic [7:0] addr, input logic [15:0] data);
    load_enable  = 1'b1;
    load_address = addr;
    load_data    = data;
    tick();
    load_enable  = 1'b0;
  endtask

  task automatic add_vec(input logic rst, input logic st, input logic stl, input logic [15:0] ins,
                         input logic v, input logic [7:0] pc, input logic b, input logic h);
    vec_t t;
    t.rst = rst; t.start = st; t.stall = stl; t.exp_instr = ins;
    t.exp_valid = v; t.exp_pc = pc; t.exp_busy = b; t.exp_halted = h;
    vecs.push_back(t);
  endtask

  initial begin
    idle_inputs();
    #2;

    // Table: reset, basic run to sentinel, then a rerun with a 3-cycle stall.
    add_vec(1, 0, 0, 16'h9000, 0, 0, 0, 0);
    add_vec(0, 1, 0, 16'h9000, 0, 0, 1, 0);
    add_vec(0, 0, 1, 16'h9000, 0, 0, 1, 0);
    add_vec(0, 0, 0, 16'h0123, 1, 0, 1, 0);
    add_vec(0, 0, 0, 16'h1456, 1, 1, 1, 0);
    add_vec(0, 0, 0, 16'h9000, 0, 2, 0, 1);
    add_vec(0, 0, 1, 16'h9000, 0, 2, 0, 1);
    add_vec(0, 1, 0, 16'h9000, 0, 0, 1, 0);
    add_vec(0, 0, 0, 16'h9000, 0, 0, 1, 0);
    add_vec(0, 0, 0, 16'h0123, 1, 0, 1, 0);
    add_vec(0, 1, 1, 16'h0123, 1, 0, 1, 0);
    add_vec(0, 0, 1, 16'h0123, 1, 0, 1, 0);
    add_vec(0, 0, 1, 16'h0123, 1, 0, 1, 0);
    add_vec(0, 0, 0, 16'h1456, 1, 1, 1, 0);
    add_vec(0, 0, 0, 16'h9000, 0, 2, 0, 1);

    power_on_reset_signal = 1'b1;
    tick();
    power_on_reset_signal = 1'b0;
    load_word(8'd0, 16'h0123);
    load_word(8'd1, 16'h1456);
    load_word(8'd2, 16'hFFFF);

    foreach (vecs[i]) begin
      power_on_reset_signal = vecs[i].rst;
      start = vecs[i].start;
      stall = vecs[i].stall;
      tick();
      check($sformatf("vec%0d", i), vecs[i].exp_instr, vecs[i].exp_valid, vecs[i].exp_pc,
            vecs[i].exp_busy, vecs[i].exp_halted);
    end
    idle_inputs();

    // Full memory without sentinel: 256 issues, then halt at PC 255 with no wrap.
    for (int a = 0; a < 256; a++) load_word(8'(a), 16'hA001);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    for (int k = 0; k < 256; k++) begin
      tick();
      check($sformatf("fill_pc%0d", k), 16'hA001, 1, 8'(k), 1, 0);
    end
    tick();
    check("fill_end", 16'h9000, 0, 8'd255, 0, 1);
    tick();
    check("fill_end_hold", 16'h9000, 0, 8'd255, 0, 1);

    // Reset in RUN at PC 5, then rerun without reloading.
    load_word(8'd0, 16'h1234);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    for (int k = 0; k < 6; k++) tick();
    check("pre_reset_pc5", 16'hA001, 1, 8'd5, 1, 0);
    power_on_reset_signal = 1'b1; tick(); power_on_reset_signal = 1'b0;
    check("reset_in_run", 16'h9000, 0, 8'd0, 0, 0);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check("rerun_mem0", 16'h1234, 1, 8'd0, 1, 0);

    // Loads during RUN are ignored; loads in HALTED take effect.
    power_on_reset_signal = 1'b1; tick(); power_on_reset_signal = 1'b0;
    load_word(8'd1, 16'h2222);
    load_word(8'd2, 16'hFFFF);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    load_enable = 1'b1; load_address = 8'd1; load_data = 16'h7777;
    tick();
    check("run_load_issue0", 16'h1234, 1, 8'd0, 1, 0);
    tick();
    load_enable = 1'b0;
    check("run_load_issue1", 16'h2222, 1, 8'd1, 1, 0);
    tick();
    check("run_load_halt", 16'h9000, 0, 8'd2, 0, 1);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    check("run_load_dropped", 16'h2222, 1, 8'd1, 1, 0);
    tick();
    load_word(8'd1, 16'h7777);
    check("halted_after_load", 16'h9000, 0, 8'd2, 0, 1);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    check("halted_load_seen", 16'h7777, 1, 8'd1, 1, 0);
    tick();

    // Sentinel at address 0: valid never rises.
    load_word(8'd0, 16'hFFFF);
    start = 1'b1; tick(); start = 1'b0;
    check("sent0_prime", 16'h9000, 0, 8'd0, 1, 0);
    tick();
    check("sent0_run", 16'h9000, 0, 8'd0, 1, 0);
    tick();
    check("sent0_halt", 16'h9000, 0, 8'd0, 0, 1);

    // Load and start in the same cycle: write lands before the first fetch.
    load_enable = 1'b1; load_address = 8'd0; load_data = 16'h5555; start = 1'b1;
    tick();
    load_enable = 1'b0; start = 1'b0;
    tick(); tick();
    check("load_with_start", 16'h5555, 1, 8'd0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
